nmea_sentence_scheduler: RTL and testbench

- Framing and commit controller between the UART character recoverer (char_r: o_char / o_finished) and downstream NMEA field consumers.
- Tracks "$TTSSS,payload*HH\r\n" framing, accumulates the XOR checksum and buffers payload bytes.
- Releases a sentence downstream only after checksum and CR/LF pass, as a ready/valid byte stream tagged with talker ID, sentence ID and field index.
- Failed, filtered or overlong sentences are discarded; only failed and overlong ones are counted as drops.

---
 rtl/nmea_pkg.sv | 34 +++
 rtl/nmea_char_buf.sv | 26 ++
 rtl/nmea_sentence_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_nmea_sentence_scheduler.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmea_pkg.sv
// Shared definitions for the NMEA sentence scheduler.
// Provides the framing FSM state type, the ASCII framing characters and a
// hex-digit decoder used for the two checksum characters after '*'.
`timescale 1ns/1ps
package nmea_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_TI, ST_SI, ST_SEP, ST_DATA,
    ST_CK1, ST_CK2, ST_CR, ST_LF, ST_DRAIN
  } state_e;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  typedef struct packed {
    logic       legal;
    logic [3:0] nibble;
  } hex_t;

  // Only '0'-'9' and upper-case 'A'-'F' are legal checksum digits.
  function automatic hex_t hex_decode(input logic [7:0] c);
    hex_t r;
    r.legal  = 1'b1;
    r.nibble = 4'h0;
    if (c >= 8'h30 && c <= 8'h39)      r.nibble = c[3:0];
    else if (c >= 8'h41 && c <= 8'h46) r.nibble = c[3:0] + 4'd9;
    else                               r.legal  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/nmea_char_buf.sv
// Payload byte store for one sentence: 2**AW x 8 RAM with synchronous write
// and a registered read port.
// Ports: i_clk clock; i_we/i_waddr/i_wdata write port;
//        i_raddr read address, o_rdata = mem[i_raddr] one cycle later.
`timescale 1ns/1ps
module nmea_char_buf #(
  parameter int AW = 7
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] mem_q [2**AW];

  // NOTE: storage and its read register carry no reset so the array maps to
  // RAM; the scheduler never presents a byte it has not written first.
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    o_rdata <= mem_q[i_raddr];
  end

endmodule

// File: rtl/nmea_sentence_scheduler.sv
// Framing and commit controller for NMEA sentences "$TTSSS,payload*HH\r\n".
// Buffers the payload, checks XOR checksum and CR/LF, and only then streams
// the payload out as a ready/valid byte stream tagged with field index.
// Ports: i_clk, i_rst (async, active-low); i_char/i_char_valid input chars;
//        i_filter_en/i_filter_si sentence-ID filter; i_ready downstream accept;
//        o_valid/o_data/o_last/o_field_idx payload stream; o_talker_id and
//        o_sentence_id of the delivered sentence; o_sentence_ok commit pulse;
//        o_drop_cnt saturating drop count; o_busy = FSM not IDLE.
`timescale 1ns/1ps
module nmea_sentence_scheduler
  import nmea_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_char,
  input  logic        i_char_valid,
  input  logic        i_filter_en,
  input  logic [23:0] i_filter_si,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_last,
  output logic [7:0]  o_field_idx,
  output logic [15:0] o_talker_id,
  output logic [23:0] o_sentence_id,
  output logic        o_sentence_ok,
  output logic [7:0]  o_drop_cnt,
  output logic        o_busy
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL    = {1'b1, {AW{1'b0}}};

  state_e      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [7:0]  csum_q;
  logic [3:0]  ck_hi_q;
  logic        ck_ok_q;
  logic [15:0] talker_q, tid_q;
  logic [23:0] si_q, sid_q;
  logic [AW:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [7:0]  field_q, drop_q;
  logic        ok_q;
  logic [7:0]  rdata;

  logic start, drop, fail, commit, buf_we, csum_en;
  logic cap_ti, cap_si, ck1_ld, ck2_ld;
  logic is_dollar, in_frame, xfer, last;
  logic [23:0] si_full;
  hex_t hexd;

  always_comb begin
    hexd      = hex_decode(i_char);
    is_dollar = (i_char == CH_DOLLAR);
    in_frame  = (state_q != ST_IDLE) && (state_q != ST_DRAIN);
    si_full   = {si_q[15:0], i_char};
    xfer      = o_valid && i_ready;
    last      = ((rd_ptr_q + PTR_ONE) == wr_ptr_q);
  end

  // State register.
  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control strobes.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    start = 1'b0; drop = 1'b0; fail = 1'b0; commit = 1'b0;
    buf_we = 1'b0; csum_en = 1'b0; cap_ti = 1'b0; cap_si = 1'b0;
    ck1_ld = 1'b0; ck2_ld = 1'b0;
    if (in_frame && i_char_valid && is_dollar) begin
      // A new '$' abandons the partial sentence and restarts framing.
      drop = 1'b1; start = 1'b1; state_d = ST_TI;
    end else begin
      case (state_q)
        ST_IDLE: if (i_char_valid && is_dollar) begin
          start = 1'b1; state_d = ST_TI;
        end
        ST_TI: if (i_char_valid) begin
          cap_ti = 1'b1; csum_en = 1'b1;
          if (cnt_q == 2'd1) state_d = ST_SI;
        end
        ST_SI: if (i_char_valid) begin
          cap_si = 1'b1; csum_en = 1'b1;
          if (cnt_q == 2'd2)
            state_d = (i_filter_en && si_full != i_filter_si) ? ST_IDLE : ST_SEP;
        end
        ST_SEP: if (i_char_valid) begin
          if (i_char == CH_COMMA) begin
            csum_en = 1'b1; state_d = ST_DATA;
          end else if (i_char == CH_STAR) state_d = ST_CK1;
          else fail = 1'b1;
        end
        ST_DATA: if (i_char_valid) begin
          if (i_char == CH_STAR)     state_d = ST_CK1;
          else if (wr_ptr_q == FULL) fail = 1'b1;  // overflow
          else begin
            csum_en = 1'b1; buf_we = 1'b1;
          end
        end
        ST_CK1: if (i_char_valid) begin
          if (hexd.legal) begin ck1_ld = 1'b1; state_d = ST_CK2; end
          else fail = 1'b1;
        end
        ST_CK2: if (i_char_valid) begin
          if (hexd.legal) begin ck2_ld = 1'b1; state_d = ST_CR; end
          else fail = 1'b1;
        end
        ST_CR: if (i_char_valid) begin
          if (i_char == CH_CR) state_d = ST_LF;
          else fail = 1'b1;
        end
        ST_LF: if (i_char_valid) begin
          if (i_char == CH_LF && ck_ok_q) begin
            commit  = 1'b1;
            state_d = (wr_ptr_q != '0) ? ST_DRAIN : ST_IDLE;
          end else fail = 1'b1;
        end
        ST_DRAIN: begin
          if (i_char_valid && is_dollar) drop = 1'b1;
          if (xfer && last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (fail) begin
      drop = 1'b1; state_d = ST_IDLE;
    end
  end

  // Outputs: the RAM read register holds the presented byte; gating by
  // o_valid keeps the stream outputs at zero outside DRAIN.
  always_comb begin
    o_valid       = (state_q == ST_DRAIN);
    o_busy        = (state_q != ST_IDLE);
    o_data        = o_valid ? rdata : 8'h00;
    o_last        = o_valid && last;
    o_field_idx   = o_valid ? field_q : 8'h00;
    o_talker_id   = tid_q;
    o_sentence_id = sid_q;
    o_sentence_ok = ok_q;
    o_drop_cnt    = drop_q;
  end

  // The RAM is addressed with the next read pointer so its registered output
  // always equals mem[rd_ptr_q] and stays put while the stream is stalled.
  always_comb begin
    rd_ptr_d = '0;
    if (state_q == ST_DRAIN && !(xfer && last))
      rd_ptr_d = xfer ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0; csum_q <= '0; ck_hi_q <= '0; ck_ok_q <= 1'b0;
      talker_q <= '0; si_q <= '0; tid_q <= '0; sid_q <= '0;
      wr_ptr_q <= '0; rd_ptr_q <= '0; field_q <= '0; drop_q <= '0;
      ok_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      ok_q     <= commit;
      if (start)        cnt_q <= 2'd0;
      else if (cap_ti)  cnt_q <= cnt_q[0] ? 2'd0 : 2'd1;
      else if (cap_si)  cnt_q <= cnt_q + 2'd1;
      if (start)        csum_q <= 8'h00;
      else if (csum_en) csum_q <= csum_q ^ i_char;
      if (cap_ti) talker_q <= {talker_q[7:0], i_char};
      if (cap_si) si_q     <= si_full;
      if (ck1_ld) ck_hi_q  <= hexd.nibble;
      if (ck2_ld) ck_ok_q  <= ({ck_hi_q, hexd.nibble} == csum_q);
      if (start || fail) wr_ptr_q <= '0;
      else if (buf_we)   wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (commit) begin
        tid_q <= talker_q; sid_q <= si_q; field_q <= 8'd1;
      end else if (xfer && rdata == CH_COMMA) begin
        field_q <= field_q + 8'd1;
      end
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  nmea_char_buf #(.AW(AW)) u_buf (
    .i_clk   (i_clk),
    .i_we    (buf_we),
    .i_waddr (wr_ptr_q[AW-1:0]),
    .i_wdata (i_char),
    .i_raddr (rd_ptr_d[AW-1:0]),
    .o_rdata (rdata)
  );

endmodule

// File: tb/tb_nmea_sentence_scheduler.sv
`timescale 1ns/1ps
module tb_nmea_sentence_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_char = 8'h00;
  logic        i_char_valid = 1'b0;
  logic        i_filter_en = 1'b0;
  logic [23:0] i_filter_si = 24'h0;
  logic        i_ready = 1'b1;
  logic        o_valid, o_last, o_sentence_ok, o_busy;
  logic [7:0]  o_data, o_field_idx, o_drop_cnt;
  logic [15:0] o_talker_id;
  logic [23:0] o_sentence_id;

  nmea_sentence_scheduler #(.AW(7)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_char(i_char), .i_char_valid(i_char_valid),
    .i_filter_en(i_filter_en), .i_filter_si(i_filter_si), .i_ready(i_ready),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_field_idx(o_field_idx),
    .o_talker_id(o_talker_id), .o_sentence_id(o_sentence_id),
    .o_sentence_ok(o_sentence_ok), .o_drop_cnt(o_drop_cnt), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic [7:0] f;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   xfers = 0;
  int   ok_cnt = 0;
  int   exp_drop = 0;
  logic hold_v = 1'b0;
  exp_t held;

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge i_clk) begin
    exp_t got;
    exp_t e;
    got = '{d: o_data, last: o_last, f: o_field_idx};
    if (!i_rst) hold_v = 1'b0;
    else begin
      if (o_sentence_ok) ok_cnt++;
      if (hold_v) begin
        vectors++;
        if (o_valid !== 1'b1 || got !== held) begin
          miscompares++;
          $display("FAIL stall_hold: got valid=%b %h required valid=1 %h", o_valid, got, held);
        end
      end
      hold_v = 1'b0;
      if (o_valid) begin
        if (i_ready) begin
          xfers++;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_byte: got %h required none", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              miscompares++;
              $display("FAIL stream_byte: got d=%h last=%b f=%0d required d=%h last=%b f=%0d",
                       got.d, got.last, got.f, e.d, e.last, e.f);
            end
          end
        end else begin
          hold_v = 1'b1;
          held   = got;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c);
    i_char = c;
    i_char_valid = 1'b1;
    tick();
    i_char_valid = 1'b0;
    tick();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic send_crlf();
    send_char(8'h0D);
    send_char(8'h0A);
  endtask

  // Model of the delivered stream: field index starts at 1 and advances on
  // the byte after each ','; the final byte is marked last.
  task automatic push_payload(input string p);
    logic [7:0] f;
    exp_t e;
    f = 8'd1;
    for (int i = 0; i < p.len(); i++) begin
      e.d = p[i];
      e.f = f;
      e.last = (i == p.len() - 1);
      exp_q.push_back(e);
      if (p[i] == 8'h2C) f = f + 8'd1;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_timeout: got pending=%0d busy=%b required pending=0 busy=0",
               name, exp_q.size(), o_busy);
      exp_q.delete();
    end
  endtask

  task automatic check_drop(input string name);
    vectors++;
    if (o_drop_cnt !== exp_drop[7:0]) begin
      miscompares++;
      $display("FAIL %s_drop: got %0d required %0d", name, o_drop_cnt, exp_drop);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({o_valid, o_data, o_last, o_field_idx, o_sentence_ok, o_busy} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_stream: got %b%h%b%h%b%b required all zero",
               o_valid, o_data, o_last, o_field_idx, o_sentence_ok, o_busy);
    end
    vectors++;
    if ({o_talker_id, o_sentence_id, o_drop_cnt} !== 48'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got %h %h %h required zero", o_talker_id, o_sentence_id, o_drop_cnt);
    end
    i_rst = 1'b1;
    tick();
    vectors++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got busy=%b valid=%b required 0 0", o_busy, o_valid);
    end
  endtask

  task automatic test_pass();
    int  ok0;
    logic seen;
    ok0 = ok_cnt;
    i_ready = 1'b1;
    push_payload("1,2");
    send_str("$GPGLL,1,2*53");
    send_char(8'h0D);
    i_char = 8'h0A;
    i_char_valid = 1'b1;
    tick();
    i_char_valid = 1'b0;
    seen = o_valid;
    vectors++;
    if (o_sentence_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL pass_ok_pulse: got %b required 1", o_sentence_ok);
    end
    if (!seen) begin
      tick();
      seen = o_valid;
    end
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("FAIL pass_latency: got valid=%b required 1 within 2 cycles", seen);
    end
    wait_idle("pass", 100);
    vectors++;
    if (ok_cnt - ok0 !== 1) begin
      miscompares++;
      $display("FAIL pass_ok_count: got %0d required 1", ok_cnt - ok0);
    end
    vectors++;
    if (o_talker_id !== 16'h4750 || o_sentence_id !== 24'h474C4C) begin
      miscompares++;
      $display("FAIL pass_ids: got %h %h required 4750 474c4c", o_talker_id, o_sentence_id);
    end
    check_drop("pass");
  endtask

  task automatic test_cksum_fail();
    int ok0, x0;
    ok0 = ok_cnt;
    x0 = xfers;
    send_str("$GPGLL,1,2*54");
    send_crlf();
    exp_drop++;
    check_drop("cksum");
    vectors++;
    if (ok_cnt != ok0 || xfers != x0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cksum_silent: got ok=%0d xfers=%0d busy=%b required 0 0 0",
               ok_cnt - ok0, xfers - x0, o_busy);
    end
  endtask

  task automatic test_empty_payload();
    int ok0, x0;
    ok0 = ok_cnt;
    x0 = xfers;
    send_str("$GPGLL*50");
    send_crlf();
    vectors++;
    if (ok_cnt - ok0 != 1 || xfers != x0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_payload: got ok=%0d xfers=%0d busy=%b required 1 0 0",
               ok_cnt - ok0, xfers - x0, o_busy);
    end
    check_drop("empty");
  endtask

  task automatic test_backpressure();
    int ok0, x0;
    ok0 = ok_cnt;
    x0 = xfers;
    i_ready = 1'b0;
    push_payload("1,2");
    fork
      begin
        send_str("$GPGLL,1,2*53");
        send_crlf();
      end
      begin
        int n;
        n = 0;
        while (!o_valid && n < 200) begin
          tick();
          n++;
        end
        repeat (10) tick();
        for (int k = 0; k < 12; k++) begin
          i_ready = ~i_ready;
          tick();
        end
        i_ready = 1'b1;
      end
    join
    wait_idle("bp", 100);
    vectors++;
    if (xfers - x0 != 3 || ok_cnt - ok0 != 1) begin
      miscompares++;
      $display("FAIL bp_transfers: got xfers=%0d ok=%0d required 3 1", xfers - x0, ok_cnt - ok0);
    end
  endtask

  task automatic test_resync_badhex();
    int ok0;
    ok0 = ok_cnt;
    push_payload("1");
    send_str("$GPG$GPGLL,1*4D");
    send_crlf();
    wait_idle("resync", 100);
    exp_drop++;
    check_drop("resync");
    vectors++;
    if (ok_cnt - ok0 != 1) begin
      miscompares++;
      $display("FAIL resync_ok: got %0d required 1", ok_cnt - ok0);
    end
    send_str("$GPGLL,1*4g");
    send_crlf();
    exp_drop++;
    check_drop("badhex");
  endtask

  task automatic test_filter();
    int ok0, x0;
    ok0 = ok_cnt;
    x0 = xfers;
    i_filter_en = 1'b1;
    i_filter_si = 24'h524D43;
    send_str("$GPGLL,1,2*53");
    send_crlf();
    vectors++;
    if (ok_cnt != ok0 || xfers != x0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL filter_reject: got ok=%0d xfers=%0d busy=%b required 0 0 0",
               ok_cnt - ok0, xfers - x0, o_busy);
    end
    check_drop("filter");
    i_filter_si = 24'h474C4C;
    push_payload("1,2");
    send_str("$GPGLL,1,2*53");
    send_crlf();
    wait_idle("filter_accept", 100);
    vectors++;
    if (ok_cnt - ok0 != 1) begin
      miscompares++;
      $display("FAIL filter_accept: got %0d required 1", ok_cnt - ok0);
    end
    i_filter_en = 1'b0;
  endtask

  task automatic test_overflow();
    string p128;
    int x0;
    p128 = "";
    for (int i = 0; i < 128; i++) p128 = {p128, "A"};
    x0 = xfers;
    push_payload(p128);
    send_str({"$GPGLL,", p128, "*7C"});
    send_crlf();
    wait_idle("full", 400);
    vectors++;
    if (xfers - x0 != 128) begin
      miscompares++;
      $display("FAIL full_count: got %0d required 128", xfers - x0);
    end
    check_drop("full");
    x0 = xfers;
    send_str({"$GPGLL,", p128, "A*7C"});
    send_crlf();
    exp_drop++;
    check_drop("overflow");
    vectors++;
    if (xfers != x0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_idle: got xfers=%0d busy=%b required 0 0", xfers - x0, o_busy);
    end
  endtask

  task automatic test_drop_saturate();
    for (int i = 0; i < 301; i++) send_char(8'h24);
    exp_drop = exp_drop + 300;
    if (exp_drop > 255) exp_drop = 255;
    check_drop("saturate");
    send_str("$GPGLL*00");
    send_crlf();
    check_drop("saturate_hold");
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL saturate_idle: got busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_reset_drain();
    int n, x0;
    i_ready = 1'b0;
    push_payload("1,2");
    send_str("$GPGLL,1,2*53");
    send_crlf();
    n = 0;
    while (!o_valid && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (o_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_drain_valid: got %b required 1", o_valid);
    end
    x0 = xfers;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    #1 i_rst = 1'b0;
    #1;
    vectors++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || xfers - x0 != 1) begin
      miscompares++;
      $display("FAIL rst_drain_async: got valid=%b busy=%b xfers=%0d required 0 0 1",
               o_valid, o_busy, xfers - x0);
    end
    exp_q.delete();
    exp_drop = 0;
    repeat (2) tick();
    i_rst = 1'b1;
    tick();
    check_drop("rst_drain");
    i_ready = 1'b1;
    push_payload("1,2");
    send_str("$GPGLL,1,2*53");
    send_crlf();
    wait_idle("post_rst", 100);
    vectors++;
    if (o_talker_id !== 16'h4750 || o_sentence_id !== 24'h474C4C) begin
      miscompares++;
      $display("FAIL post_rst_ids: got %h %h required 4750 474c4c", o_talker_id, o_sentence_id);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_cksum_fail();
    test_empty_payload();
    test_backpressure();
    test_resync_badhex();
    test_filter();
    test_overflow();
    test_drop_saturate();
    test_reset_drain();
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
